// File: rtl/tw_addr_sched_if.sv
// ---------------------------------------------------------------------------
// tw_addr_sched_if
// Bundle between the stage input stream, the twiddle address scheduler and
// the twiddle ROM wrapper.
//   master modport : stream side; drives start / intt_in / in_valid and
//                    observes the scheduler outputs.
//   slave modport  : the scheduler; consumes the stream controls and drives
//                    raddr, rd_en, tw_one, tw_valid, intt, busy, done,
//                    frame_err and frame_cnt.
// ---------------------------------------------------------------------------
interface tw_addr_sched_if #(
  parameter int LOGN = 4
);
  logic            start;
  logic            intt_in;
  logic            in_valid;
  logic [LOGN-1:0] raddr;
  logic            rd_en;
  logic            tw_one;
  logic            tw_valid;
  logic            intt;
  logic            busy;
  logic            done;
  logic            frame_err;
  logic [15:0]     frame_cnt;

  modport master (
    output start, intt_in, in_valid,
    input  raddr, rd_en, tw_one, tw_valid, intt, busy, done, frame_err, frame_cnt
  );

  modport slave (
    input  start, intt_in, in_valid,
    output raddr, rd_en, tw_one, tw_valid, intt, busy, done, frame_err, frame_cnt
  );
endinterface

// File: rtl/tw_addr_sched.sv
// ---------------------------------------------------------------------------
// tw_addr_sched
// Per-stage twiddle address scheduler for one butterfly stage of the SDF NTT
// pipeline. Counts the N = 2**LOGN samples of a frame, drives the twiddle ROM
// read address / enable, flags unity twiddles, and produces a valid flag
// aligned with the ROM output (rd_en delayed by DELAY_BROM cycles).
//
// Parameters
//   LOGN        log2 of the frame length; width of the counter and raddr
//   STAGE       butterfly stage index (0..LOGN-1)
//   DELAY_BROM  ROM read latency in cycles (>= 1)
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   tw_addr_sched_if.slave:
//           start/intt_in/in_valid in; raddr, rd_en, tw_one, tw_valid,
//           intt, busy, done, frame_err, frame_cnt out
//
// Build option
//   TW_FRAME_CNT_EN  when defined, frame_cnt counts done pulses (saturating
//                    at 16'hFFFF); otherwise frame_cnt is tied to zero.
// ---------------------------------------------------------------------------
module tw_addr_sched #(
  parameter int LOGN       = 4,
  parameter int STAGE      = 2,
  parameter int DELAY_BROM = 2
) (
  input logic          clk,
  input logic          rst,
  tw_addr_sched_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LOGN-1:0] CNT_LAST = {LOGN{1'b1}};
  localparam logic [LOGN-1:0] LO_MASK  = LOGN'((1 << STAGE) - 1);

  // Low STAGE bits of the local index, zero-extended (all zero for STAGE 0).
  function automatic logic [LOGN-1:0] tw_addr(input logic [LOGN-1:0] k);
    return k & LO_MASK;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state, state_nxt;
  logic [LOGN-1:0] cnt, cnt_nxt;

  logic            acc_p0;
  logic            last_p0;
  logic            relatch_p0;
  logic            err_p0;
  logic            bfly_p0;
  logic [LOGN-1:0] k_p0;

  logic [LOGN-1:0] raddr_p1;
  logic            rd_en_p1;
  logic            tw_one_p1;
  logic            done_p1;
  logic            err_p1;
  logic            intt_p1;
  logic            busy;
  logic            tw_valid;

  // ---- stage p0: decode of the incoming sample ----
  always_comb begin
    last_p0    = (state == RUN) && bus.in_valid && (cnt == CNT_LAST);
    acc_p0     = bus.in_valid && ((state == RUN) || bus.start);
    // A sample that arrives with the accepted start in IDLE is sample 0.
    k_p0       = (state == RUN) ? cnt : '0;
    bfly_p0    = (STAGE != 0) && k_p0[STAGE];
    relatch_p0 = bus.start && ((state == IDLE) || last_p0);
    err_p0     = (state == RUN) && bus.start && !last_p0;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          cnt_nxt   = bus.in_valid ? LOGN'(1) : '0;
        end
      end
      RUN: begin
        if (bus.in_valid) cnt_nxt = cnt + 1'b1;
        // Back-to-back start on the last sample keeps the FSM in RUN.
        if (last_p0 && !bus.start) state_nxt = IDLE;
        if (last_p0 && bus.start)  cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM output logic
  always_comb begin
    busy = (state == RUN);
  end

  // ---- stage p1: registered address / status ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_p1  <= '0;
      rd_en_p1  <= 1'b0;
      tw_one_p1 <= 1'b0;
      done_p1   <= 1'b0;
      err_p1    <= 1'b0;
      intt_p1   <= 1'b0;
    end else begin
      done_p1 <= last_p0;
      err_p1  <= err_p0;
      if (relatch_p0) intt_p1 <= bus.intt_in;
      if (acc_p0) begin
        rd_en_p1  <= bfly_p0;
        tw_one_p1 <= !bfly_p0;
        // raddr holds its previous value on non-butterfly samples.
        if (bfly_p0) raddr_p1 <= tw_addr(k_p0);
      end else begin
        rd_en_p1  <= 1'b0;
        tw_one_p1 <= 1'b0;
      end
    end
  end

  // ---- stage p2..: rd_en delayed to line up with ROM dout ----
  generate
    if (DELAY_BROM == 1) begin : g_vld_d1
      logic vld_p2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= rd_en_p1;
      end
      assign tw_valid = vld_p2;
    end else begin : g_vld_dn
      logic [DELAY_BROM-1:0] vld_sr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_sr <= '0;
        else     vld_sr <= {vld_sr[DELAY_BROM-2:0], rd_en_p1};
      end
      assign tw_valid = vld_sr[DELAY_BROM-1];
    end
  endgenerate

`ifdef TW_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          frame_cnt_q <= 16'h0000;
    else if (done_p1) frame_cnt_q <= sat_inc16(frame_cnt_q);
  end
  assign bus.frame_cnt = frame_cnt_q;
`else
  logic [15:0] unused_sat;
  assign unused_sat    = sat_inc16(16'h0000);
  assign bus.frame_cnt = 16'h0000;
`endif

  assign bus.raddr     = raddr_p1;
  assign bus.rd_en     = rd_en_p1;
  assign bus.tw_one    = tw_one_p1;
  assign bus.tw_valid  = tw_valid;
  assign bus.intt      = intt_p1;
  assign bus.busy      = busy;
  assign bus.done      = done_p1;
  assign bus.frame_err = err_p1;

endmodule

// File: tb/tb_tw_addr_sched.sv
// ---------------------------------------------------------------------------
// tb_tw_addr_sched
// Bench for tw_addr_sched (LOGN=4, STAGE=2, DELAY_BROM=2) with a second
// STAGE=0 instance fed by the same stream. Expected outputs come from a
// frame-level model: sample position within the frame, butterfly test by
// integer division, address by modulo, ROM valid through a history queue.
// ---------------------------------------------------------------------------
module tb_tw_addr_sched;
  localparam int LOGN  = 4;
  localparam int N     = 16;
  localparam int STAGE = 2;
  localparam int DLY   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tw_addr_sched_if #(.LOGN(LOGN)) bus ();
  tw_addr_sched_if #(.LOGN(LOGN)) bus0 ();

  assign bus0.start    = bus.start;
  assign bus0.in_valid = bus.in_valid;
  assign bus0.intt_in  = bus.intt_in;

  tw_addr_sched #(.LOGN(LOGN), .STAGE(STAGE), .DELAY_BROM(DLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  tw_addr_sched #(.LOGN(LOGN), .STAGE(0), .DELAY_BROM(DLY)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int checks = 0;
  int errors = 0;

  // model state
  bit m_run;
  int m_k;
  bit m_intt;
  int m_fcnt;
  int m_raddr;
  int vq[$];
  // expected outputs after the next edge
  bit e_rd, e_one, e_done, e_err, e_tw, e_one0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_k = 0; m_intt = 0; m_fcnt = 0; m_raddr = 0;
    e_rd = 0; e_one = 0; e_done = 0; e_err = 0; e_tw = 0; e_one0 = 0;
    vq.delete();
    for (int i = 0; i < DLY; i++) vq.push_back(0);
  endtask

  task automatic model_step(input bit s, input bit v, input bit ii);
    bit acc, last, err, bfly;
    int k;
    acc = 0; last = 0; err = 0; k = 0;
    if (!m_run) begin
      if (s) begin
        m_run  = 1;
        m_intt = ii;
        if (v) begin acc = 1; k = 0; m_k = 1; end
        else m_k = 0;
      end
    end else begin
      if (v) begin
        acc  = 1;
        k    = m_k;
        last = (m_k == N - 1);
        m_k  = (m_k + 1) % N;
      end
      if (s) begin
        if (last) m_intt = ii;
        else      err = 1;
      end
      if (last && !s) m_run = 0;
    end
    bfly = acc && (((k / (1 << STAGE)) % 2) == 1);
    e_rd   = bfly;
    e_one  = acc && !bfly;
    e_one0 = acc;
    if (bfly) m_raddr = k % (1 << STAGE);
    e_done = last;
    e_err  = err;
    if (last) begin
`ifdef TW_FRAME_CNT_EN
      if (m_fcnt < 65535) m_fcnt++;
`endif
    end
    vq.push_back(int'(e_rd));
    e_tw = (vq.pop_front() != 0);
  endtask

  task automatic check_all();
    chk("raddr",     32'(bus.raddr),     32'(m_raddr));
    chk("rd_en",     32'(bus.rd_en),     32'(e_rd));
    chk("tw_one",    32'(bus.tw_one),    32'(e_one));
    chk("tw_valid",  32'(bus.tw_valid),  32'(e_tw));
    chk("intt",      32'(bus.intt),      32'(m_intt));
    chk("busy",      32'(bus.busy),      32'(m_run));
    chk("done",      32'(bus.done),      32'(e_done));
    chk("frame_err", 32'(bus.frame_err), 32'(e_err));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));
    chk("s0_rd_en",  32'(bus0.rd_en),    32'd0);
    chk("s0_tw_one", 32'(bus0.tw_one),   32'(e_one0));
    chk("s0_raddr",  32'(bus0.raddr),    32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_raddr"},    32'(bus.raddr),     32'd0);
    chk({tag, "_rd_en"},    32'(bus.rd_en),     32'd0);
    chk({tag, "_tw_one"},   32'(bus.tw_one),    32'd0);
    chk({tag, "_tw_valid"}, 32'(bus.tw_valid),  32'd0);
    chk({tag, "_intt"},     32'(bus.intt),      32'd0);
    chk({tag, "_busy"},     32'(bus.busy),      32'd0);
    chk({tag, "_done"},     32'(bus.done),      32'd0);
    chk({tag, "_ferr"},     32'(bus.frame_err), 32'd0);
    chk({tag, "_fcnt"},     32'(bus.frame_cnt), 32'd0);
  endtask

  task automatic cycle(input bit s, input bit v, input bit ii);
    bus.start    = s;
    bus.in_valid = v;
    bus.intt_in  = ii;
    model_step(s, v, ii);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check_all();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.intt_in  = 1'b0;
    model_reset();
    #1;
    check_zero("por");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("rst_rel");

    // idle, then in_valid without start
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1);

    // contiguous frame, start with sample 0
    for (int i = 0; i < N; i++) cycle(i == 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);

    // INTT frame: start alone, gapped samples, intt_in toggling
    cycle(1, 0, 1);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(0, 0, 1'($urandom));
      cycle(0, 1, 1'($urandom));
    end
    cycle(0, 0, 0);

    // NTT frame following
    for (int i = 0; i < N; i++) cycle(i == 0, 1, 0);
    cycle(0, 0, 0);

    // start at sample 7 rejected; start at sample 15 back-to-back
    for (int i = 0; i < N; i++) cycle(i == 0 || i == 7 || i == N - 1, 1, (i == N - 1));
    for (int i = 0; i < N; i++) cycle(0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);

    // reset at sample 9 of a frame
    for (int i = 0; i < 9; i++) cycle(i == 0, 1, 1);
    rst = 1'b1;
    #1;
    check_zero("abort");
    model_reset();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    for (int i = 0; i < N; i++) cycle(i == 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
